// File: rtl/ld_ext_gather.sv
// Gathers a two-beat memory load (low = 64-bit mantissa, high = sign/exponent)
// into one 80-bit extended-precision operand with a valid/ready handoff.
module ld_ext_gather #(
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             beat_valid,
  input  logic             beat_hi,
  input  logic [63:0]      beat_data,
  input  logic [TAG_W-1:0] beat_tag,
  output logic             beat_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [79:0]      out_A,
  output logic [79:0]      out_An,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_den,
  output logic             out_ovf,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_LO = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t           state_q;
  logic [63:0]      mant_q;
  logic [15:0]      se_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             beat_acc_s;

  // In FULL a new beat can only enter when the held operand leaves this cycle.
  always_comb begin
    beat_ready = 1'b1;
    if (state_q == FULL) begin
      beat_ready = out_ready;
    end else begin
      beat_ready = 1'b1;
    end
  end

  assign beat_acc_s = beat_valid & beat_ready;

  // Gather FSM with operand registers and the registered protocol-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= 64'd0;
      se_q    <= 16'd0;
      tag_q   <= {TAG_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (beat_acc_s && !beat_hi) begin
              mant_q  <= beat_data;
              tag_q   <= beat_tag;
              state_q <= HAVE_LO;
            end else if (beat_acc_s && beat_hi) begin
              err_q <= 1'b1;
            end
          end
          HAVE_LO: begin
            if (beat_acc_s && beat_hi) begin
              se_q    <= beat_data[15:0];
              state_q <= FULL;
            end else if (beat_acc_s && !beat_hi) begin
              // Duplicate low beat: newest one wins, but flag the ordering fault.
              mant_q <= beat_data;
              tag_q  <= beat_tag;
              err_q  <= 1'b1;
            end
          end
          FULL: begin
            if (out_ready) begin
              if (beat_acc_s && !beat_hi) begin
                mant_q  <= beat_data;
                tag_q   <= beat_tag;
                state_q <= HAVE_LO;
              end else if (beat_acc_s && beat_hi) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_A     = {se_q, mant_q};
  assign out_An    = ~{se_q, mant_q};
  assign out_tag   = tag_q;
  assign out_den   = (se_q[14:0] == 15'd0);
  assign out_ovf   = (se_q[14:0] == 15'h7fff);
  assign err       = err_q;

endmodule

// File: doc/ld_ext_gather.md
LD_EXT_GATHER -- requirements
Module: ld_ext_gather

Interface
REQ-001 SHALL have parameter TAG_W, default 9, giving the destination-register tag width.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port flush, input, 1: cancels any partially or fully gathered operand.
REQ-005 SHALL have port beat_valid, input, 1: a memory beat is offered.
REQ-006 SHALL have port beat_hi, input, 1: 0 = low beat (mantissa), 1 = high beat (sign/exponent).
REQ-007 SHALL have port beat_data, input, 64: beat payload; high beat uses [15:0] only.
REQ-008 SHALL have port beat_tag, input, TAG_W: tag; sampled on low beat only.
REQ-009 SHALL have port beat_ready, output, 1: beat accepted when beat_valid & beat_ready.
REQ-010 SHALL have port out_valid, output, 1: assembled 80-bit extended operand available.
REQ-011 SHALL have port out_ready, input, 1: consumer (native-format converter) takes operand.
REQ-012 SHALL have port out_A, output, 80: {sign, exp[14:0], mantissa[63:0]}.
REQ-013 SHALL have port out_An, output, 80: bitwise complement of out_A.
REQ-014 SHALL have port out_tag, output, TAG_W: tag captured with the low beat.
REQ-015 SHALL have port out_den, output, 1: out_A[78:64]==0.
REQ-016 SHALL have port out_ovf, output, 1: out_A[78:64]==15'h7fff.
REQ-017 SHALL have port err, output, 1: one-cycle pulse on a beat-order protocol violation.

Function
REQ-018 SHALL implement states IDLE, HAVE_LO, FULL; out_valid=1 exactly in FULL.
REQ-019 SHALL drive beat_ready=1 in IDLE and HAVE_LO, and in FULL only when out_ready=1.
REQ-020 SHALL, in IDLE on accepted low beat, store beat_data as mantissa, store beat_tag, go to HAVE_LO.
REQ-021 SHALL, in IDLE on accepted high beat, discard it, pulse err, stay IDLE.
REQ-022 SHALL, in HAVE_LO on accepted high beat, store beat_data[15:0] as {sign,exp}, go to FULL.
REQ-023 SHALL, in HAVE_LO on accepted low beat, overwrite mantissa and tag, pulse err, stay HAVE_LO.
REQ-024 SHALL, in FULL with out_ready=1 and no accepted beat, go to IDLE.
REQ-025 SHALL, in FULL with out_ready=1 and accepted low beat, hand off the current operand and go to HAVE_LO with the new beat stored (zero-bubble back-to-back).
REQ-026 SHALL, in FULL with out_ready=1 and accepted high beat, hand off, pulse err, go to IDLE.
REQ-027 SHALL hold out_A, out_An, out_tag, out_den, out_ovf stable while out_valid=1 and out_ready=0.
REQ-028 SHALL compute out_den and out_ovf from the registered operand, valid only while out_valid=1.
REQ-029 SHALL give latency: out_valid asserts the cycle after the high beat is accepted.
REQ-030 SHALL, on flush, go to IDLE next cycle from any state, regardless of beats or out_ready; a beat offered in the flush cycle is dropped without err.
REQ-031 SHALL give flush priority over all transitions; a FULL operand flushed with out_ready=1 counts as not delivered.

Reset
REQ-032 SHALL, with rst=1 at a clock edge, enter IDLE and zero mantissa, sign/exp and tag registers.
REQ-033 SHALL give these output reset values: out_valid=0, err=0, out_A=0, out_An=all ones, out_tag=0, out_den=1, out_ovf=0, beat_ready=1.
REQ-034 SHALL give rst priority over flush and beats; reset mid-gather discards the partial operand.

Verification
REQ-035 SHALL cover: low 64'h8000_0000_0000_0000, tag 5, then high 16'h3fff -> next cycle out_valid=1, out_A=80'h3fff_8000_0000_0000_0000, out_tag=5, out_den=0, out_ovf=0.
REQ-036 SHALL cover: high beat first in IDLE -> err=1 for one cycle, out_valid stays 0, state IDLE.
REQ-037 SHALL cover: operand held with out_ready=0 for 3 cycles -> outputs stable and beat_ready=0; then out_ready=1 with a new low beat -> handoff and HAVE_LO in the same cycle.
REQ-038 SHALL cover: high 16'h7fff -> out_ovf=1; high 16'h8000 -> out_den=1 and out_A[79]=1.
REQ-039 SHALL cover: flush in HAVE_LO and in FULL -> IDLE next cycle, out_valid=0, no err.
REQ-040 SHALL cover: rst asserted in FULL -> next cycle out_valid=0, out_An=all ones.
